add_pipe_nbits: RTL and testbench

//  Parametrised, pipelined ripple-carry adder with a valid/ready handshake.

---
 rtl/add_pipe_nbits.sv | 124 ++++++++++++
 tb/tb_add_pipe_nbits.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_nbits.sv
// Pipelined ripple-carry adder: the carry chain is split into STAGES registered segments.
// Optional subtract mode (i_sub) is enabled by defining ADD_PIPE_SUB_EN.
module add_pipe_nbits #(
  parameter int WIDTH  = 34,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_one,
  input  logic [WIDTH-1:0] i_data_two,
  input  logic             i_carry,
`ifdef ADD_PIPE_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] valid_q, valid_d;

  logic             adv;
  logic [WIDTH-1:0] b_first;
  logic             cin_first;
  logic [WIDTH-1:0] a_in, b_in, sum_tmp;
  logic             c;
  int               prev, lo, hi;

  // Subtraction folds into addition: A + ~B + 1.
  always_comb begin
`ifdef ADD_PIPE_SUB_EN
    b_first   = i_sub ? ~i_data_two : i_data_two;
    cin_first = i_sub ? 1'b1 : i_carry;
`else
    b_first   = i_data_two;
    cin_first = i_carry;
`endif
  end

  assign adv     = i_ready || !valid_q[STAGES-1];
  assign o_ready = adv;
  assign o_valid = valid_q[STAGES-1];
  assign o_data  = sum_q[STAGES-1];
  assign o_carry = carry_q[STAGES-1];

  // Each stage ripples its own bit range [lo,hi); empty ranges pass the carry through.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    a_in    = '0;
    b_in    = '0;
    sum_tmp = '0;
    c       = 1'b0;
    prev    = 0;
    lo      = 0;
    hi      = 0;
    if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        prev = (s > 0) ? s - 1 : 0;
        if (s == 0) begin
          a_in       = i_valid ? i_data_one : '0;
          b_in       = i_valid ? b_first : '0;
          c          = i_valid && cin_first;
          sum_tmp    = '0;
          valid_d[0] = i_valid;
        end else begin
          a_in       = a_q[prev];
          b_in       = b_q[prev];
          c          = carry_q[prev];
          sum_tmp    = sum_q[prev];
          valid_d[s] = valid_q[prev];
        end
        lo = s * SEG;
        hi = (s == STAGES - 1) ? WIDTH : (s + 1) * SEG;
        if (lo > WIDTH) lo = WIDTH;
        if (hi > WIDTH) hi = WIDTH;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= lo && i < hi) begin
            sum_tmp[i] = a_in[i] ^ b_in[i] ^ c;
            c          = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
          end
        end
        a_d[s]     = a_in;
        b_d[s]     = b_in;
        sum_d[s]   = sum_tmp;
        carry_d[s] = c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_add_pipe_nbits.sv
// Self-checking bench for add_pipe_nbits: a 34/2 instance with random handshake and a
// 33/4 instance for uneven segments, both checked against a transaction-level model.
module tb_add_pipe_nbits;

  localparam int W1 = 34;
  localparam int S1 = 2;
  localparam int W2 = 33;
  localparam int S2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          v1, rdy1, cin1, sub1;
  logic [W1-1:0] a1, b1;
  logic          o_ready1, o_valid1, o_carry1;
  logic [W1-1:0] o_data1;

  logic          v2, rdy2, cin2, sub2;
  logic [W2-1:0] a2, b2;
  logic          o_ready2, o_valid2, o_carry2;
  logic [W2-1:0] o_data2;

  add_pipe_nbits #(.WIDTH(W1), .STAGES(S1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(o_ready1),
    .i_data_one(a1), .i_data_two(b1), .i_carry(cin1),
`ifdef ADD_PIPE_SUB_EN
    .i_sub(sub1),
`endif
    .o_valid(o_valid1), .i_ready(rdy1), .o_data(o_data1), .o_carry(o_carry1)
  );

  add_pipe_nbits #(.WIDTH(W2), .STAGES(S2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(o_ready2),
    .i_data_one(a2), .i_data_two(b2), .i_carry(cin2),
`ifdef ADD_PIPE_SUB_EN
    .i_sub(sub2),
`endif
    .o_valid(o_valid2), .i_ready(rdy2), .o_data(o_data2), .o_carry(o_carry2)
  );

  // Transaction-level model: one slot per cycle of latency, whole pipe stalls together.
  logic        mv1 [S1];
  logic [63:0] md1 [S1];
  logic        mv2 [S2];
  logic [63:0] md2 [S2];

  int checks = 0;
  int fails  = 0;

  function automatic logic [63:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub, input int w);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [63:0] cc;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? (~b & mask) : (b & mask);
    cc   = sub ? 64'd1 : {63'd0, cin};
    return ((a & mask) + bb + cc) & ((mask << 1) | 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < S1; k++) begin mv1[k] = 1'b0; md1[k] = '0; end
    for (int k = 0; k < S2; k++) begin mv2[k] = 1'b0; md2[k] = '0; end
  endtask

  task automatic check_output();
    check("o_valid1", {63'd0, o_valid1}, {63'd0, mv1[S1-1]});
    check("o_ready1", {63'd0, o_ready1}, {63'd0, rdy1 || !mv1[S1-1]});
    if (mv1[S1-1]) check("sum1", {29'd0, o_carry1, o_data1}, md1[S1-1]);
    check("o_valid2", {63'd0, o_valid2}, {63'd0, mv2[S2-1]});
    check("o_ready2", {63'd0, o_ready2}, {63'd0, rdy2 || !mv2[S2-1]});
    if (mv2[S2-1]) check("sum2", {30'd0, o_carry2, o_data2}, md2[S2-1]);
  endtask

  // Called at the falling edge with inputs already set; returns at the next falling edge.
  task automatic apply_stimulus();
    logic adv1, adv2;
    #1;
    check_output();
    adv1 = rdy1 || !mv1[S1-1];
    adv2 = rdy2 || !mv2[S2-1];
    @(posedge clk);
    if (adv1) begin
      for (int k = S1 - 1; k > 0; k--) begin mv1[k] = mv1[k-1]; md1[k] = md1[k-1]; end
      mv1[0] = v1;
      md1[0] = ref_sum({30'd0, a1}, {30'd0, b1}, cin1, sub1, W1);
    end
    if (adv2) begin
      for (int k = S2 - 1; k > 0; k--) begin mv2[k] = mv2[k-1]; md2[k] = md2[k-1]; end
      mv2[0] = v2;
      md2[0] = ref_sum({31'd0, a2}, {31'd0, b2}, cin2, sub2, W2);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    v1 = 1'b0; v2 = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1; sub1 = 1'b0; sub2 = 1'b0;
    repeat (n) apply_stimulus();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid1", {63'd0, o_valid1}, 64'd0);
    check("rst_data1",  {30'd0, o_data1},  64'd0);
    check("rst_carry1", {63'd0, o_carry1}, 64'd0);
    check("rst_ready1", {63'd0, o_ready1}, 64'd1);
    check("rst_valid2", {63'd0, o_valid2}, 64'd0);
    check("rst_data2",  {31'd0, o_data2},  64'd0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    v1 = 1'b0; rdy1 = 1'b1; cin1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    v2 = 1'b0; rdy2 = 1'b1; cin2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    clear_model();
    #2;
    do_reset();
    idle(2);

    // Carry ripples across the segment boundary.
    v1 = 1'b1; a1 = 34'h3_FFFF_FFFF; b1 = '0; cin1 = 1'b1; rdy1 = 1'b1;
    apply_stimulus();
    idle(1);
    check("t1_valid", {63'd0, o_valid1}, 64'd1);
    check("t1_data",  {30'd0, o_data1},  64'd0);
    check("t1_carry", {63'd0, o_carry1}, 64'd1);
    idle(2);

    // Back-to-back accepts with extreme and random operands.
    for (int n = 0; n < 8; n++) begin
      v1 = 1'b1; rdy1 = 1'b1; cin1 = n[0];
      a1 = (n == 0) ? '1 : W1'({$urandom(), $urandom()});
      b1 = (n == 0) ? '1 : W1'({$urandom(), $urandom()});
      apply_stimulus();
    end
    idle(S1 + 1);

    // Backpressure with a full pipe; inputs keep arriving while stalled.
    rdy1 = 1'b0;
    for (int n = 0; n < 7; n++) begin
      v1 = 1'b1; cin1 = 1'b0;
      a1 = W1'({$urandom(), $urandom()});
      b1 = W1'({$urandom(), $urandom()});
      apply_stimulus();
    end
    v1 = 1'b0; rdy1 = 1'b1;
    repeat (S1 + 2) apply_stimulus();

    // Reset with two transactions in flight.
    v1 = 1'b1; rdy1 = 1'b1; a1 = 34'h1234; b1 = 34'h4321; cin1 = 1'b0;
    apply_stimulus();
    a1 = 34'h2_0000_0001;
    apply_stimulus();
    do_reset();
    idle(S2 + 2);

    // Uneven segments on the 33-bit, 4-stage instance.
    v2 = 1'b1; a2 = 33'h1_2345_6789; b2 = 33'h0_FEDC_BA98; cin2 = 1'b0;
    apply_stimulus();
    idle(S2 - 1);
    check("t5_valid", {63'd0, o_valid2}, 64'd1);
    check("t5_data",  {31'd0, o_data2},  64'h0_2222_2221);
    check("t5_carry", {63'd0, o_carry2}, 64'd1);
    idle(2);

`ifdef ADD_PIPE_SUB_EN
    v1 = 1'b1; a1 = 34'd5; b1 = 34'd7; sub1 = 1'b1; cin1 = 1'b0;
    apply_stimulus();
    idle(S1 - 1);
    check("t6_data",  {30'd0, o_data1},  64'h3_FFFF_FFFE);
    check("t6_carry", {63'd0, o_carry1}, 64'd0);
    idle(2);
`endif

    // Random traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      v1   = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      cin1 = $urandom_range(0, 1);
      a1   = W1'({$urandom(), $urandom()});
      b1   = W1'({$urandom(), $urandom()});
      v2   = ($urandom_range(0, 1) != 0);
      rdy2 = ($urandom_range(0, 2) != 0);
      cin2 = $urandom_range(0, 1);
      a2   = W2'({$urandom(), $urandom()});
      b2   = W2'({$urandom(), $urandom()});
`ifdef ADD_PIPE_SUB_EN
      sub1 = $urandom_range(0, 1);
      sub2 = $urandom_range(0, 1);
`endif
      apply_stimulus();
    end
    idle(S2 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
